// File: rtl/vram_arbiter_if.sv
// VRAM arbiter bus bundle: video fetch port, CPU request port and the
// synchronous RAM port. The arbiter takes the slave view; the environment
// (display controller, CPU and RAM model) takes the master view.
interface vram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              vid_rd;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_dout;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic [7:0]        cpu_wait;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  vid_rd, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output vid_dout, cpu_ack, cpu_rdata, cpu_wait,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output vid_rd, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  vid_dout, cpu_ack, cpu_rdata, cpu_wait,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// VRAM arbiter: video reads pass straight through to the RAM with fixed
// one-cycle latency; CPU writes are posted into a one-entry buffer that
// drains in the first video-free cycle; CPU reads wait for an empty buffer
// and a video-free cycle so read-after-write order is preserved.
module vram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic           clk_pixel,
    input  logic           nreset,
    input  logic           srst,
    vram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_ACK     = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_buf_valid;
    logic [ADDR_W-1:0] r_buf_addr;
    logic [DATA_W-1:0] r_buf_data;
    logic              r_cpu_ack;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [7:0]        r_cpu_wait;

    logic              w_idle;
    logic              w_drain;
    logic              w_wr_accept;
    logic              w_rd_issue;
    logic              w_ram_en;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;

    // Video always owns the RAM when it reads; the buffer drains before any
    // CPU read may issue, which keeps read-after-write ordering.
    assign w_idle      = (r_state == S_IDLE);
    assign w_drain     = r_buf_valid & ~bus.vid_rd;
    assign w_wr_accept = w_idle & bus.cpu_req & bus.cpu_we & ~r_buf_valid;
    assign w_rd_issue  = w_idle & bus.cpu_req & ~bus.cpu_we & ~r_buf_valid & ~bus.vid_rd;

    // RAM port mux: video, then buffer drain, then CPU read; idle otherwise.
    always_comb begin
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = bus.cpu_addr;
        w_ram_wdata = r_buf_data;
        if (bus.vid_rd) begin
            w_ram_en   = 1'b1;
            w_ram_we   = 1'b0;
            w_ram_addr = bus.vid_addr;
        end else if (r_buf_valid) begin
            w_ram_en   = 1'b1;
            w_ram_we   = 1'b1;
            w_ram_addr = r_buf_addr;
        end else if (w_rd_issue) begin
            w_ram_en   = 1'b1;
            w_ram_we   = 1'b0;
            w_ram_addr = bus.cpu_addr;
        end else begin
            w_ram_en   = 1'b0;
            w_ram_we   = 1'b0;
        end
    end

    assign bus.ram_en    = w_ram_en;
    assign bus.ram_we    = w_ram_we;
    assign bus.ram_addr  = w_ram_addr;
    assign bus.ram_wdata = w_ram_wdata;
    assign bus.vid_dout  = bus.ram_rdata;
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.cpu_wait  = r_cpu_wait;

    // Posted-write buffer: load on write acceptance, clear when drained.
    // Reset drops any pending entry so a discarded write never reaches RAM.
    always_ff @(posedge clk_pixel or negedge nreset) begin
        if (!nreset) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= {ADDR_W{1'b0}};
            r_buf_data  <= {DATA_W{1'b0}};
        end else if (srst) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= {ADDR_W{1'b0}};
            r_buf_data  <= {DATA_W{1'b0}};
        end else if (w_wr_accept) begin
            r_buf_valid <= 1'b1;
            r_buf_addr  <= bus.cpu_addr;
            r_buf_data  <= bus.cpu_wdata;
        end else if (w_drain) begin
            r_buf_valid <= 1'b0;
        end
    end

    // CPU-side FSM with registered ack, read data and blocked-cycle counter.
    always_ff @(posedge clk_pixel or negedge nreset) begin
        if (!nreset) begin
            r_state     <= S_IDLE;
            r_cpu_ack   <= 1'b0;
            r_cpu_rdata <= {DATA_W{1'b0}};
            r_cpu_wait  <= 8'd0;
        end else if (srst) begin
            r_state     <= S_IDLE;
            r_cpu_ack   <= 1'b0;
            r_cpu_rdata <= {DATA_W{1'b0}};
            r_cpu_wait  <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cpu_ack <= 1'b0;
                    if (w_wr_accept) begin
                        r_state   <= S_ACK;
                        r_cpu_ack <= 1'b1;
                    end else if (w_rd_issue) begin
                        r_state <= S_RD_WAIT;
                    end else if (bus.cpu_req) begin
                        // blocked this cycle: count, saturating
                        if (r_cpu_wait != 8'hFF) begin
                            r_cpu_wait <= r_cpu_wait + 8'd1;
                        end
                    end else begin
                        // no request (or request withdrawn): nothing is waiting
                        r_cpu_wait <= 8'd0;
                    end
                end
                S_RD_WAIT: begin
                    r_cpu_rdata <= bus.ram_rdata;
                    r_state     <= S_ACK;
                    r_cpu_ack   <= 1'b1;
                end
                S_ACK: begin
                    r_cpu_ack  <= 1'b0;
                    r_cpu_wait <= 8'd0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_cpu_ack <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized CPU/video
// traffic. CPU expectations come from a golden memory updated in CPU order;
// a monitor pops them on every cpu_ack. Video reads are checked against the
// bench's RAM model one cycle after the strobe.
module tb_vram_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;

    logic clk_pixel = 1'b0;
    logic nreset    = 1'b1;
    logic srst      = 1'b0;

    vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_pixel (clk_pixel),
        .nreset    (nreset),
        .srst      (srst),
        .bus       (bus)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct packed {
        logic       is_rd;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] mem  [0:65535];
    logic [7:0] gold [0:65535];
    logic [7:0] ram_rdata_r;
    int         checks = 0;
    int         errors = 0;
    logic       rand_vid = 1'b0;

    // Synchronous RAM model (environment).
    always @(posedge clk_pixel) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            ram_rdata_r       <= mem[bus.ram_addr];
        end
    end
    assign bus.ram_rdata = ram_rdata_r;

    function automatic logic [7:0] init_val(input logic [15:0] a);
        if (a == 16'h1234) return 8'h5A;
        return a[7:0] ^ a[15:8];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: CPU acks against the scoreboard, video reads against RAM model.
    initial begin
        logic       prev_ack = 1'b0;
        logic       vpend = 1'b0;
        logic [7:0] vexp = 8'h00;
        exp_t       e;
        forever begin
            @(negedge clk_pixel);
            if (bus.cpu_ack) begin
                chk("ack_one_cycle", {31'd0, prev_ack}, 32'd0);
                if (sb_q.size() == 0) begin
                    chk("spurious_ack", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    if (e.is_rd) chk("cpu_rdata", {24'd0, bus.cpu_rdata}, {24'd0, e.data});
                end
            end
            prev_ack = bus.cpu_ack;
            if (vpend) chk("vid_dout", {24'd0, bus.vid_dout}, {24'd0, vexp});
            vpend = 1'b0;
            if (bus.vid_rd) begin
                chk("vid_ram_en_we", {30'd0, bus.ram_en, bus.ram_we}, 32'd2);
                chk("vid_ram_addr", {16'd0, bus.ram_addr}, {16'd0, bus.vid_addr});
                vexp  = mem[bus.vid_addr];
                vpend = 1'b1;
            end
        end
    end

    // Background random video traffic.
    initial begin
        forever begin
            @(posedge clk_pixel);
            #1;
            if (rand_vid) begin
                bus.vid_rd   = ($urandom_range(0, 2) == 0);
                bus.vid_addr = 16'h0040 + 16'($urandom_range(0, 15));
            end
        end
    end

    task automatic start_req(input logic we, input logic [15:0] a, input logic [7:0] d, input logic track);
        exp_t e;
        e.is_rd = ~we;
        e.data  = we ? d : gold[a];
        if (track) begin
            sb_q.push_back(e);
            if (we) gold[a] = d;
        end
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_req   = 1'b1;
    endtask

    task automatic wait_ack(input int budget, output int lat);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk_pixel);
            n++;
            if (bus.cpu_ack || n >= budget) break;
        end
        if (!bus.cpu_ack) begin
            chk("ack_timeout", 32'd1, 32'd0);
            if (sb_q.size() > 0) void'(sb_q.pop_back());
        end
        bus.cpu_req = 1'b0;
        lat = n;
    endtask

    task automatic txn(input logic we, input logic [15:0] a, input logic [7:0] d, input int budget, output int lat);
        @(posedge clk_pixel);
        #1;
        start_req(we, a, d, 1'b1);
        wait_ack(budget, lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acks;
        bus.vid_rd    = 1'b0;
        bus.vid_addr  = 16'h0000;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 16'h0000;
        bus.cpu_wdata = 8'h00;
        for (int i = 0; i < 65536; i++) begin
            mem[i]  <= init_val(16'(i));
            gold[i]  = init_val(16'(i));
        end
        #1 nreset = 1'b0;

        // Reset values and video pass-through while in reset
        repeat (2) @(negedge clk_pixel);
        chk("rst_cpu_ack", {31'd0, bus.cpu_ack}, 32'd0);
        chk("rst_cpu_rdata", {24'd0, bus.cpu_rdata}, 32'd0);
        chk("rst_cpu_wait", {24'd0, bus.cpu_wait}, 32'd0);
        @(posedge clk_pixel); #1;
        bus.vid_rd = 1'b1; bus.vid_addr = 16'h1234;
        @(negedge clk_pixel);
        chk("vid_addr_same_cycle", {16'd0, bus.ram_addr}, 32'h1234);
        chk("vid_en_in_reset", {31'd0, bus.ram_en}, 32'd1);
        @(posedge clk_pixel); #1;
        bus.vid_rd = 1'b0;
        @(negedge clk_pixel);
        chk("vid_dout_5a", {24'd0, bus.vid_dout}, 32'h5A);
        @(posedge clk_pixel); #3 nreset = 1'b1;

        // Posted write, video idle
        txn(1'b1, 16'h0100, 8'hAA, 10, lat);
        chk("posted_wr_lat", lat, 2);
        @(negedge clk_pixel);
        chk("posted_wr_mem", {24'd0, mem[16'h0100]}, 32'hAA);

        // Posted write while video busy: acked at once, drains after video
        @(posedge clk_pixel); #1; bus.vid_rd = 1'b1; bus.vid_addr = 16'h0010;
        txn(1'b1, 16'h0101, 8'hBB, 10, lat);
        chk("busy_wr_lat", lat, 2);
        repeat (3) @(negedge clk_pixel);
        chk("busy_wr_not_drained", {24'd0, mem[16'h0101]}, {24'd0, init_val(16'h0101)});
        @(posedge clk_pixel); #1; bus.vid_rd = 1'b0;
        repeat (2) @(negedge clk_pixel);
        chk("busy_wr_drained", {24'd0, mem[16'h0101]}, 32'hBB);

        // Back-to-back writes with video busy
        @(posedge clk_pixel); #1; bus.vid_rd = 1'b1;
        txn(1'b1, 16'h0102, 8'h11, 10, lat);
        chk("b2b_first_lat", lat, 2);
        @(posedge clk_pixel); #1;
        start_req(1'b1, 16'h0103, 8'h22, 1'b1);
        acks = 0;
        repeat (6) begin
            @(negedge clk_pixel);
            if (bus.cpu_ack) acks++;
        end
        chk("b2b_second_held", acks, 0);
        @(posedge clk_pixel); #1; bus.vid_rd = 1'b0;
        wait_ack(10, lat);
        chk("b2b_second_lat", lat, 3);
        chk("b2b_first_drained", {24'd0, mem[16'h0102]}, 32'h11);
        repeat (2) @(negedge clk_pixel);
        chk("b2b_second_drained", {24'd0, mem[16'h0103]}, 32'h22);

        // Starvation: read blocked by 300 cycles of video
        @(posedge clk_pixel); #1; bus.vid_rd = 1'b1;
        start_req(1'b0, 16'h0100, 8'h00, 1'b1);
        repeat (4) @(negedge clk_pixel);
        chk("wait_count_3", {24'd0, bus.cpu_wait}, 32'd3);
        repeat (300) @(posedge clk_pixel);
        @(negedge clk_pixel);
        chk("wait_saturated", {24'd0, bus.cpu_wait}, 32'd255);
        @(posedge clk_pixel); #1; bus.vid_rd = 1'b0;
        wait_ack(10, lat);
        chk("starve_rd_lat", lat, 3);
        chk("wait_at_ack", {24'd0, bus.cpu_wait}, 32'd255);
        @(negedge clk_pixel);
        chk("wait_cleared", {24'd0, bus.cpu_wait}, 32'd0);

        // Read-after-write with video busy for 5 cycles
        @(posedge clk_pixel); #1; bus.vid_rd = 1'b1;
        txn(1'b1, 16'h0200, 8'h33, 10, lat);
        chk("raw_wr_lat", lat, 2);
        @(posedge clk_pixel); #1;
        start_req(1'b0, 16'h0200, 8'h00, 1'b1);
        repeat (5) @(posedge clk_pixel);
        #1; bus.vid_rd = 1'b0;
        wait_ack(10, lat);
        chk("raw_rd_lat", lat, 4);

        // Withdrawn request: counter clears, no access, no ack
        @(posedge clk_pixel); #1; bus.vid_rd = 1'b1;
        start_req(1'b0, 16'h0050, 8'h00, 1'b0);
        repeat (3) @(negedge clk_pixel);
        chk("withdraw_wait_2", {24'd0, bus.cpu_wait}, 32'd2);
        @(posedge clk_pixel); #1; bus.cpu_req = 1'b0; bus.vid_rd = 1'b0;
        repeat (2) @(negedge clk_pixel);
        chk("withdraw_wait_clr", {24'd0, bus.cpu_wait}, 32'd0);

        // Reset in RD_WAIT: no ack, outputs zero, next read fine
        @(posedge clk_pixel); #1;
        start_req(1'b0, 16'h0040, 8'h00, 1'b0);
        @(posedge clk_pixel); #2 nreset = 1'b0;
        #1;
        chk("rst_rd_ack", {31'd0, bus.cpu_ack}, 32'd0);
        chk("rst_rd_rdata", {24'd0, bus.cpu_rdata}, 32'd0);
        chk("rst_rd_wait", {24'd0, bus.cpu_wait}, 32'd0);
        bus.cpu_req = 1'b0;
        @(posedge clk_pixel); @(posedge clk_pixel); #3 nreset = 1'b1;
        acks = 0;
        repeat (5) begin
            @(negedge clk_pixel);
            if (bus.cpu_ack) acks++;
        end
        chk("rst_rd_no_ack", acks, 0);
        txn(1'b0, 16'h0040, 8'h00, 10, lat);
        chk("post_rst_rd_lat", lat, 3);

        // Reset with buffer full: entry discarded, RAM untouched
        @(posedge clk_pixel); #1; bus.vid_rd = 1'b1;
        txn(1'b1, 16'h0300, 8'h77, 10, lat);
        chk("buf_rst_wr_lat", lat, 2);
        @(posedge clk_pixel); #2 nreset = 1'b0;
        @(posedge clk_pixel); #2 nreset = 1'b1;
        gold[16'h0300] = init_val(16'h0300);
        bus.vid_rd = 1'b0;
        repeat (4) @(negedge clk_pixel);
        chk("buf_rst_discard", {24'd0, mem[16'h0300]}, {24'd0, init_val(16'h0300)});

        // Randomized traffic
        rand_vid = 1'b1;
        for (int n = 0; n < 150; n++) begin
            logic        we;
            logic [15:0] a;
            logic [7:0]  d;
            we = 1'($urandom_range(0, 1));
            a  = 16'h0040 + 16'($urandom_range(0, 15));
            d  = 8'($urandom);
            txn(we, a, d, 100, lat);
            if ($urandom_range(0, 3) == 0) @(posedge clk_pixel);
        end
        rand_vid = 1'b0;
        @(posedge clk_pixel); #1; bus.vid_rd = 1'b0;
        repeat (4) @(negedge clk_pixel);
        for (int i = 0; i < 16; i++) begin
            chk("final_mem", {24'd0, mem[16'h0040 + 16'(i)]}, {24'd0, gold[16'h0040 + 16'(i)]});
        end
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
